// File: rtl/control_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// control_sequencer -- hardwired T-state control unit for a single-bus CPU.
// Optional macro SEQ_MEM_WAIT_EN stalls the memory states until mem_ready.
// Revision 1.0
// ----------------------------------------------------------------------------
module control_sequencer #(
  parameter int              IR_W   = 32,
  parameter int              OP_W   = 5,
  parameter logic [OP_W-1:0] ADD_OP = OP_W'(5'b00011)
) (
  input  logic            Clock,
  input  logic            clr,
  input  logic            run,
  input  logic [IR_W-1:0] IR,
  input  logic            con_ff,
  input  logic            mem_ready,
  output logic            PC_out,
  output logic            PC_enable,
  output logic            IncPC,
  output logic            MAR_enable,
  output logic            Read,
  output logic            MDR_enable,
  output logic            MDR_out,
  output logic            IR_enable,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            R_in,
  output logic            R_out,
  output logic            BA_out,
  output logic            Y_enable,
  output logic            Z_enable,
  output logic            ZLow_out,
  output logic            C_out,
  output logic            con_in,
  output logic            RAM_write_enable,
  output logic [OP_W-1:0] alu_op,
  output logic [3:0]      step,
  output logic            halted,
  output logic            illegal
);

  localparam logic [OP_W-1:0] OP_LD     = OP_W'(5'b00000);
  localparam logic [OP_W-1:0] OP_ST     = OP_W'(5'b00010);
  localparam logic [OP_W-1:0] OP_ALU_LO = OP_W'(5'b00011);
  localparam logic [OP_W-1:0] OP_ALU_HI = OP_W'(5'b01100);
  localparam logic [OP_W-1:0] OP_BR     = OP_W'(5'b10011);
  localparam logic [OP_W-1:0] OP_JR     = OP_W'(5'b10100);
  localparam logic [OP_W-1:0] OP_JAL    = OP_W'(5'b10101);
  localparam logic [OP_W-1:0] OP_NOP    = OP_W'(5'b11000);
  localparam logic [OP_W-1:0] OP_HALT   = OP_W'(5'b11001);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  typedef struct packed {
    logic            pc_out;
    logic            pc_enable;
    logic            inc_pc;
    logic            mar_enable;
    logic            read;
    logic            mdr_enable;
    logic            mdr_out;
    logic            ir_enable;
    logic            gra;
    logic            grb;
    logic            grc;
    logic            r_in;
    logic            r_out;
    logic            ba_out;
    logic            y_enable;
    logic            z_enable;
    logic            zlow_out;
    logic            c_out;
    logic            con_in;
    logic            ram_we;
    logic [OP_W-1:0] alu_op;
    logic            illegal;
    logic            halted;
    logic            br_t6;
  } ctl_t;

  state_t          state;
  state_t          state_nx;
  logic [OP_W-1:0] opcode;
  logic [OP_W-1:0] opcode_nx;
  ctl_t            ctl;
  logic            mem_hold;

  logic unused_ir;
  assign unused_ir = ^IR[IR_W-OP_W-1:0];

  function automatic logic is_alu(input logic [OP_W-1:0] op);
    return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
  endfunction

  function automatic logic is_mem(input logic [OP_W-1:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

  function automatic logic is_known(input logic [OP_W-1:0] op);
    return is_alu(op) || is_mem(op) || (op == OP_BR) || (op == OP_JR) ||
           (op == OP_JAL) || (op == OP_NOP) || (op == OP_HALT);
  endfunction

  // True when the given execute state is the final one for this opcode.
  function automatic logic last_step(input state_t s, input logic [OP_W-1:0] op);
    logic last;
    last = 1'b0;
    case (s)
      S_T3:    last = !(is_alu(op) || is_mem(op) || (op == OP_BR) ||
                        (op == OP_JAL) || (op == OP_HALT));
      S_T4:    last = (op == OP_JAL);
      S_T5:    last = is_alu(op);
      S_T6:    last = (op == OP_BR);
      S_T7:    last = 1'b1;
      default: last = 1'b0;
    endcase
    return last;
  endfunction

  function automatic ctl_t decode(input state_t s, input logic [OP_W-1:0] op);
    ctl_t c;
    c = '0;
    case (s)
      S_T0: begin
        c.pc_out = 1'b1; c.mar_enable = 1'b1; c.inc_pc = 1'b1; c.pc_enable = 1'b1;
      end
      S_T1: begin
        c.read = 1'b1; c.mdr_enable = 1'b1;
      end
      S_T2: begin
        c.mdr_out = 1'b1; c.ir_enable = 1'b1;
      end
      S_T3: begin
        if (is_alu(op)) begin
          c.grb = 1'b1; c.r_out = 1'b1; c.y_enable = 1'b1;
        end else if (is_mem(op)) begin
          c.grb = 1'b1; c.ba_out = 1'b1; c.r_out = 1'b1; c.y_enable = 1'b1;
        end else if (op == OP_BR) begin
          c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1;
        end else if (op == OP_JR) begin
          c.gra = 1'b1; c.r_out = 1'b1; c.pc_enable = 1'b1;
        end else if (op == OP_JAL) begin
          c.pc_out = 1'b1; c.grb = 1'b1; c.r_in = 1'b1;
        end else begin
          c.illegal = !is_known(op);
        end
      end
      S_T4: begin
        if (is_alu(op)) begin
          c.grc = 1'b1; c.r_out = 1'b1; c.z_enable = 1'b1; c.alu_op = op;
        end else if (is_mem(op)) begin
          c.c_out = 1'b1; c.z_enable = 1'b1; c.alu_op = ADD_OP;
        end else if (op == OP_BR) begin
          c.pc_out = 1'b1; c.y_enable = 1'b1;
        end else if (op == OP_JAL) begin
          c.gra = 1'b1; c.r_out = 1'b1; c.pc_enable = 1'b1;
        end
      end
      S_T5: begin
        if (is_alu(op)) begin
          c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
        end else if (is_mem(op)) begin
          c.zlow_out = 1'b1; c.mar_enable = 1'b1;
        end else if (op == OP_BR) begin
          c.c_out = 1'b1; c.z_enable = 1'b1; c.alu_op = ADD_OP;
        end
      end
      S_T6: begin
        if (op == OP_LD) begin
          c.read = 1'b1; c.mdr_enable = 1'b1;
        end else if (op == OP_ST) begin
          c.gra = 1'b1; c.r_out = 1'b1; c.mdr_enable = 1'b1;
        end else if (op == OP_BR) begin
          c.br_t6 = 1'b1;
        end
      end
      S_T7: begin
        if (op == OP_LD) begin
          c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
        end else if (op == OP_ST) begin
          c.ram_we = 1'b1;
        end
      end
      S_HALT: c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

`ifdef SEQ_MEM_WAIT_EN
  always_comb begin
    mem_hold = !mem_ready &&
               ((state == S_T1) ||
                ((state == S_T6) && (opcode == OP_LD)) ||
                ((state == S_T7) && (opcode == OP_ST)));
  end
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_hold         = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    opcode_nx = opcode;
    case (state)
      S_IDLE: if (run) state_nx = S_T0;
      S_T0:   state_nx = S_T1;
      S_T1:   if (!mem_hold) state_nx = S_T2;
      S_T2: begin
        state_nx  = S_T3;
        opcode_nx = IR[IR_W-1 -: OP_W];
      end
      S_HALT: state_nx = S_HALT;
      default: begin
        if (mem_hold)
          state_nx = state;
        else if ((state == S_T3) && (opcode == OP_HALT))
          state_nx = S_HALT;
        else if (last_step(state, opcode))
          state_nx = run ? S_T0 : S_IDLE;
        else
          state_nx = state_t'(state + 4'd1);
      end
    endcase
  end

  // Strobes are decoded from the next state so they come straight off flops.
  always_ff @(posedge Clock or negedge clr) begin
    if (!clr) begin
      state  <= S_IDLE;
      opcode <= '0;
      ctl    <= '0;
    end else begin
      state  <= state_nx;
      opcode <= opcode_nx;
      ctl    <= decode(state_nx, opcode_nx);
    end
  end

  // The branch commit is the only strobe that follows con_ff within T6.
  assign PC_enable        = ctl.pc_enable | (ctl.br_t6 & con_ff);
  assign ZLow_out         = ctl.zlow_out  | (ctl.br_t6 & con_ff);
  assign PC_out           = ctl.pc_out;
  assign IncPC            = ctl.inc_pc;
  assign MAR_enable       = ctl.mar_enable;
  assign Read             = ctl.read;
  assign MDR_enable       = ctl.mdr_enable;
  assign MDR_out          = ctl.mdr_out;
  assign IR_enable        = ctl.ir_enable;
  assign Gra              = ctl.gra;
  assign Grb              = ctl.grb;
  assign Grc              = ctl.grc;
  assign R_in             = ctl.r_in;
  assign R_out            = ctl.r_out;
  assign BA_out           = ctl.ba_out;
  assign Y_enable         = ctl.y_enable;
  assign Z_enable         = ctl.z_enable;
  assign C_out            = ctl.c_out;
  assign con_in           = ctl.con_in;
  assign RAM_write_enable = ctl.ram_we;
  assign alu_op           = ctl.alu_op;
  assign halted           = ctl.halted;
  assign illegal          = ctl.illegal;
  assign step             = state;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// tb_control_sequencer -- directed checks of fetch, each instruction class,
// branch condition, memory stall (when built with SEQ_MEM_WAIT_EN), halt and async reset.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        clr, run, con_ff, mem_ready;
  logic [31:0] IR;
  logic PC_out, PC_enable, IncPC, MAR_enable, Read, MDR_enable, MDR_out, IR_enable;
  logic Gra, Grb, Grc, R_in, R_out, BA_out, Y_enable, Z_enable, ZLow_out, C_out;
  logic con_in, RAM_write_enable, halted, illegal;
  logic [4:0] alu_op;
  logic [3:0] step;

  int tests = 0;
  int fails = 0;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_T0 = 4'd1, ST_T1 = 4'd2, ST_T2 = 4'd3,
                         ST_T3 = 4'd4, ST_T4 = 4'd5, ST_T5 = 4'd6, ST_T6 = 4'd7,
                         ST_T7 = 4'd8, ST_HALT = 4'd9;

  localparam logic [19:0] PCO  = 20'h80000, PCE  = 20'h40000, INC  = 20'h20000,
                          MARE = 20'h10000, RD   = 20'h08000, MDRE = 20'h04000,
                          MDRO = 20'h02000, IRE  = 20'h01000, GRA  = 20'h00800,
                          GRB  = 20'h00400, GRC  = 20'h00200, RIN  = 20'h00100,
                          ROUT = 20'h00080, BAO  = 20'h00040, YE   = 20'h00020,
                          ZE   = 20'h00010, ZLO  = 20'h00008, CO   = 20'h00004,
                          CONI = 20'h00002, RAMW = 20'h00001;

  wire [19:0] strobes = {PC_out, PC_enable, IncPC, MAR_enable, Read, MDR_enable,
                         MDR_out, IR_enable, Gra, Grb, Grc, R_in, R_out, BA_out,
                         Y_enable, Z_enable, ZLow_out, C_out, con_in, RAM_write_enable};

  control_sequencer dut (
    .Clock(Clock), .clr(clr), .run(run), .IR(IR), .con_ff(con_ff), .mem_ready(mem_ready),
    .PC_out(PC_out), .PC_enable(PC_enable), .IncPC(IncPC), .MAR_enable(MAR_enable),
    .Read(Read), .MDR_enable(MDR_enable), .MDR_out(MDR_out), .IR_enable(IR_enable),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_in(R_in), .R_out(R_out), .BA_out(BA_out),
    .Y_enable(Y_enable), .Z_enable(Z_enable), .ZLow_out(ZLow_out), .C_out(C_out),
    .con_in(con_in), .RAM_write_enable(RAM_write_enable), .alu_op(alu_op),
    .step(step), .halted(halted), .illegal(illegal)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // flags: bit1 = halted, bit0 = illegal
  task automatic state_chk(input string tag, input logic [3:0] s, input logic [19:0] st,
                           input logic [4:0] alu, input logic [1:0] flags);
    chk({tag, ".step"}, 32'(step), 32'(s));
    chk({tag, ".strobes"}, 32'(strobes), 32'(st));
    chk({tag, ".alu_halt_ill"}, 32'({alu_op, halted, illegal}), 32'({alu, flags}));
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [31:0] opw(input logic [4:0] op);
    return {op, 27'h5A5A5A5};
  endfunction

  // Expects to be called in T0; returns one cycle after T2 (in T3).
  task automatic fetch(input string tag);
    state_chk({tag, ".T0"}, ST_T0, PCO | MARE | INC | PCE, 5'd0, 2'b00);
    tick();
    state_chk({tag, ".T1"}, ST_T1, RD | MDRE, 5'd0, 2'b00);
    tick();
    state_chk({tag, ".T2"}, ST_T2, MDRO | IRE, 5'd0, 2'b00);
    tick();
  endtask

  initial begin
    clr = 1'b0; run = 1'b0; con_ff = 1'b0; mem_ready = 1'b1; IR = opw(5'b10100);
    #2;
    state_chk("reset", ST_IDLE, 20'h0, 5'd0, 2'b00);
    clr = 1'b1; run = 1'b1;
    #1;
    chk("idle_after_release", 32'(step), 32'(ST_IDLE));
    tick();

    // jr: four cycles total
    fetch("jr");
    state_chk("jr.T3", ST_T3, GRA | ROUT | PCE, 5'd0, 2'b00);
    IR = opw(5'b00011);
    tick();

    // add: six cycles, ALU code passes through at T4
    fetch("add");
    state_chk("add.T3", ST_T3, GRB | ROUT | YE, 5'd0, 2'b00);
    tick();
    state_chk("add.T4", ST_T4, GRC | ROUT | ZE, 5'b00011, 2'b00);
    tick();
    state_chk("add.T5", ST_T5, ZLO | GRA | RIN, 5'd0, 2'b00);
    IR = opw(5'b01100);
    tick();

    // top of the ALU class
    fetch("alu12");
    tick();
    state_chk("alu12.T4", ST_T4, GRC | ROUT | ZE, 5'b01100, 2'b00);
    tick();
    IR = opw(5'b10011);
    tick();

    // br: condition sampled combinationally during T6
    fetch("br");
    state_chk("br.T3", ST_T3, GRA | ROUT | CONI, 5'd0, 2'b00);
    tick();
    state_chk("br.T4", ST_T4, PCO | YE, 5'd0, 2'b00);
    tick();
    state_chk("br.T5", ST_T5, CO | ZE, 5'b00011, 2'b00);
    tick();
    state_chk("br.T6.not_taken", ST_T6, 20'h0, 5'd0, 2'b00);
    con_ff = 1'b1;
    #1;
    state_chk("br.T6.taken", ST_T6, ZLO | PCE, 5'd0, 2'b00);
    con_ff = 1'b0;
    IR = opw(5'b00000);
    tick();

    // ld, with mem_ready low for three cycles in T6
    fetch("ld");
    state_chk("ld.T3", ST_T3, GRB | BAO | ROUT | YE, 5'd0, 2'b00);
    tick();
    state_chk("ld.T4", ST_T4, CO | ZE, 5'b00011, 2'b00);
    tick();
    state_chk("ld.T5", ST_T5, ZLO | MARE, 5'd0, 2'b00);
    tick();
    state_chk("ld.T6", ST_T6, RD | MDRE, 5'd0, 2'b00);
    mem_ready = 1'b0;
`ifdef SEQ_MEM_WAIT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      state_chk("ld.T6.hold", ST_T6, RD | MDRE, 5'd0, 2'b00);
    end
    mem_ready = 1'b1;
`endif
    tick();
    state_chk("ld.T7", ST_T7, MDRO | GRA | RIN, 5'd0, 2'b00);
    mem_ready = 1'b1;
    IR = opw(5'b00010);
    tick();

    // st, with run dropped mid-instruction: completes, then IDLE
    fetch("st");
    state_chk("st.T3", ST_T3, GRB | BAO | ROUT | YE, 5'd0, 2'b00);
    tick();
    state_chk("st.T4", ST_T4, CO | ZE, 5'b00011, 2'b00);
    tick();
    state_chk("st.T5", ST_T5, ZLO | MARE, 5'd0, 2'b00);
    run = 1'b0;
    tick();
    state_chk("st.T6", ST_T6, GRA | ROUT | MDRE, 5'd0, 2'b00);
    tick();
    state_chk("st.T7", ST_T7, RAMW, 5'd0, 2'b00);
    tick();
    state_chk("st.idle", ST_IDLE, 20'h0, 5'd0, 2'b00);
    tick();
    state_chk("st.idle_hold", ST_IDLE, 20'h0, 5'd0, 2'b00);
    run = 1'b1;
    IR = opw(5'b10101);
    tick();

    // jal
    fetch("jal");
    state_chk("jal.T3", ST_T3, PCO | GRB | RIN, 5'd0, 2'b00);
    tick();
    state_chk("jal.T4", ST_T4, GRA | ROUT | PCE, 5'd0, 2'b00);
    IR = opw(5'b11000);
    tick();

    // nop, then an unknown opcode
    fetch("nop");
    state_chk("nop.T3", ST_T3, 20'h0, 5'd0, 2'b00);
    IR = opw(5'b11111);
    tick();
    fetch("ill");
    state_chk("ill.T3", ST_T3, 20'h0, 5'd0, 2'b01);
    IR = opw(5'b00011);
    tick();

    // asynchronous reset in the middle of T5
    fetch("rst");
    tick();
    tick();
    state_chk("rst.T5", ST_T5, ZLO | GRA | RIN, 5'd0, 2'b00);
    #2;
    clr = 1'b0;
    #1;
    state_chk("rst.async", ST_IDLE, 20'h0, 5'd0, 2'b00);
    clr = 1'b1;
    IR = opw(5'b11001);
    tick();

    // halt sticks until reset
    fetch("halt");
    state_chk("halt.T3", ST_T3, 20'h0, 5'd0, 2'b00);
    tick();
    state_chk("halt.enter", ST_HALT, 20'h0, 5'd0, 2'b10);
    for (int i = 0; i < 5; i++) begin
      tick();
      state_chk("halt.hold", ST_HALT, 20'h0, 5'd0, 2'b10);
    end
    #2;
    clr = 1'b0;
    #1;
    state_chk("halt.reset", ST_IDLE, 20'h0, 5'd0, 2'b00);
    clr = 1'b1;
    run = 1'b0;
    tick();
    state_chk("halt.after_reset", ST_IDLE, 20'h0, 5'd0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
